// File: rtl/debug_io_select_pkg.sv
// Shared constants and helpers for the debug_io_select pin multiplexer.
// Lane count, input group width and select width live here so that the
// top level and the bench agree on the same geometry.
package debug_io_select_pkg;

    localparam int CH_COUNT = 4;
    localparam int IN_W     = 8;
    localparam int SEL_W    = 3;

    // Picks one bit out of a debug group. The group is masked with a one-hot
    // vector built from the select, so every input bit is read by the logic
    // even though only the selected one can influence the result.
    function automatic logic pick_bit(input logic [IN_W-1:0] grp,
                                      input logic [SEL_W-1:0] sel);
        logic [IN_W-1:0] mask;
        mask = {{(IN_W-1){1'b0}}, 1'b1} << sel;
        return |(grp & mask);
    endfunction

endpackage

// File: rtl/debug_io_sync.sv
// Two-stage single-bit synchronizer with asynchronous active-high reset.
// Used on each debug lane when DEBUG_IO_SYNC_EN is defined.
module debug_io_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Capture the asynchronous bit and let it settle through a second stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/debug_io_select.sv
// Debug pin selector: routes one chosen bit from each of four asynchronous
// debug groups to a registered 4-bit debug port, with optional per-lane
// inversion.
// Build option: define DEBUG_IO_SYNC_EN to insert a 2-flop synchronizer per
// lane ahead of the output flop (3-edge latency); without it each selected
// bit is registered once (1-edge latency).
module debug_io_select
    import debug_io_select_pkg::*;
#(
    parameter logic [SEL_W-1:0]    CH0_SEL  = 3'd0,
    parameter logic [SEL_W-1:0]    CH1_SEL  = 3'd0,
    parameter logic [SEL_W-1:0]    CH2_SEL  = 3'd0,
    parameter logic [SEL_W-1:0]    CH3_SEL  = 3'd0,
    parameter logic [CH_COUNT-1:0] INV_MASK = 4'b0000
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESET,
    input  logic [IN_W-1:0]     FSYNC_I,
    input  logic [IN_W-1:0]     FSYNC_FILTER_I,
    input  logic [IN_W-1:0]     VS_I,
    input  logic [IN_W-1:0]     AUX_I,
    output logic [CH_COUNT-1:0] DEBUG_O
);

    logic [CH_COUNT-1:0] w_pick;
    logic [CH_COUNT-1:0] w_lane;
    logic [CH_COUNT-1:0] r_debug;

    assign w_pick[0] = pick_bit(FSYNC_I,        CH0_SEL);
    assign w_pick[1] = pick_bit(FSYNC_FILTER_I, CH1_SEL);
    assign w_pick[2] = pick_bit(VS_I,           CH2_SEL);
    assign w_pick[3] = pick_bit(AUX_I,          CH3_SEL);

`ifdef DEBUG_IO_SYNC_EN
    genvar g;
    generate
        for (g = 0; g < CH_COUNT; g++) begin : g_sync
            debug_io_sync u_sync (
                .i_clk (S_AXI_ACLK),
                .i_rst (S_AXI_ARESET),
                .i_d   (w_pick[g]),
                .o_q   (w_lane[g])
            );
        end
    endgenerate
`else
    assign w_lane = w_pick;
`endif

    // Output flop holds the already-inverted lane value, so the pins come
    // straight from flops. Resetting it to INV_MASK is the same as clearing
    // the sampled value to 0 and then applying the inversion.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_debug <= INV_MASK;
        end else begin
            r_debug <= w_lane ^ INV_MASK;
        end
    end

    assign DEBUG_O = r_debug;

endmodule

// File: tb/tb_debug_io_select.sv
// Self-checking bench for debug_io_select. Two instances share the inputs:
// one with default parameters, one with non-zero selects and an inversion
// mask. Expected pin values come from a bit-index model and a delay queue.
module tb_debug_io_select;

`ifdef DEBUG_IO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam int B_S0 = 3;
    localparam int B_S1 = 7;
    localparam int B_S2 = 5;
    localparam int B_S3 = 1;
    localparam logic [3:0] B_INV = 4'b1010;

    logic       clk;
    logic       rst;
    logic [7:0] f_i;
    logic [7:0] ff_i;
    logic [7:0] vs_i;
    logic [7:0] aux_i;
    logic [3:0] dbg_a;
    logic [3:0] dbg_b;

    int n_checks;
    int n_fail;

    debug_io_select dut_a (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESET   (rst),
        .FSYNC_I        (f_i),
        .FSYNC_FILTER_I (ff_i),
        .VS_I           (vs_i),
        .AUX_I          (aux_i),
        .DEBUG_O        (dbg_a)
    );

    debug_io_select #(
        .CH0_SEL  (3'd3),
        .CH1_SEL  (3'd7),
        .CH2_SEL  (3'd5),
        .CH3_SEL  (3'd1),
        .INV_MASK (4'b1010)
    ) dut_b (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESET   (rst),
        .FSYNC_I        (f_i),
        .FSYNC_FILTER_I (ff_i),
        .VS_I           (vs_i),
        .AUX_I          (aux_i),
        .DEBUG_O        (dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane k is bit sel_k of group k, flipped when inv[k] is set.
    function automatic logic [3:0] model(input logic [7:0] f, input logic [7:0] ff,
                                         input logic [7:0] vs, input logic [7:0] aux,
                                         input int s0, input int s1, input int s2,
                                         input int s3, input logic [3:0] inv);
        int v;
        v = ((int'(f) >> s0) & 1) + 2 * ((int'(ff) >> s1) & 1)
          + 4 * ((int'(vs) >> s2) & 1) + 8 * ((int'(aux) >> s3) & 1);
        return 4'(v) ^ inv;
    endfunction

    function automatic logic [3:0] model_a();
        return model(f_i, ff_i, vs_i, aux_i, 0, 0, 0, 0, 4'b0000);
    endfunction

    function automatic logic [3:0] model_b();
        return model(f_i, ff_i, vs_i, aux_i, B_S0, B_S1, B_S2, B_S3, B_INV);
    endfunction

    task automatic set_in(input logic [7:0] f, input logic [7:0] ff,
                          input logic [7:0] vs, input logic [7:0] aux);
        f_i   = f;
        ff_i  = ff;
        vs_i  = vs;
        aux_i = aux;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            #100;
            n_checks++;
            if (dbg_a !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_a: got %b expected %b", dbg_a, 4'b0000);
            end
            n_checks++;
            if (dbg_b !== B_INV) begin
                n_fail++;
                $display("FAIL reset_b: got %b expected %b", dbg_b, B_INV);
            end
        end
        #100;
        @(negedge clk);
        rst = 1'b0;
        set_in(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] tf [5];
        logic [7:0] tff[5];
        logic [7:0] tvs[5];
        logic [7:0] tax[5];
        logic [3:0] texp[5];
        tf  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
        tff = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
        tvs = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
        tax = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        texp = '{4'b1111, 4'b1110, 4'b1101, 4'b1000, 4'b0101};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(tf[i], tff[i], tvs[i], tax[i]);
            repeat (LAT) @(negedge clk);
            n_checks++;
            if (dbg_a !== texp[i]) begin
                n_fail++;
                $display("FAIL directed_a[%0d]: got %b expected %b", i, dbg_a, texp[i]);
            end
            n_checks++;
            if (dbg_b !== model_b()) begin
                n_fail++;
                $display("FAIL directed_b[%0d]: got %b expected %b", i, dbg_b, model_b());
            end
        end
    endtask

    task automatic test_unselected();
        @(negedge clk);
        set_in(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (LAT + 1) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            set_in(8'($urandom) & 8'hFE, 8'($urandom) & 8'hFE,
                   8'($urandom) & 8'hFE, 8'($urandom) & 8'hFE);
            @(negedge clk);
            n_checks++;
            if (dbg_a !== 4'b0000) begin
                n_fail++;
                $display("FAIL unselected[%0d]: got %b expected %b", i, dbg_a, 4'b0000);
            end
        end
    endtask

    task automatic test_ch2_latency();
        int edges;
        @(negedge clk);
        set_in(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (LAT + 1) @(negedge clk);
        vs_i = 8'h20;
        edges = 0;
        while (dbg_b[2] !== 1'b1 && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_checks++;
        if (dbg_b[2] !== 1'b1 || edges != LAT) begin
            n_fail++;
            $display("FAIL ch2_rise: lane2=%b after %0d edges, expected 1 after %0d",
                     dbg_b[2], edges, LAT);
        end
        @(negedge clk);
        repeat (LAT) @(negedge clk);
        vs_i = 8'h01;
        edges = 0;
        while (dbg_b[2] !== 1'b0 && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_checks++;
        if (dbg_b[2] !== 1'b0 || edges != LAT) begin
            n_fail++;
            $display("FAIL ch2_fall: lane2=%b after %0d edges, expected 0 after %0d",
                     dbg_b[2], edges, LAT);
        end
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic test_random_stream();
        logic [7:0] q[$];
        logic [7:0] e;
        @(negedge clk);
        repeat (LAT + 1) @(negedge clk);
        for (int i = 0; i < LAT; i++) q.push_back({model_b(), model_a()});
        for (int i = 0; i < 300; i++) begin
            e = q.pop_front();
            n_checks++;
            if ({dbg_b, dbg_a} !== e) begin
                n_fail++;
                $display("FAIL stream[%0d]: got b=%b a=%b expected b=%b a=%b",
                         i, dbg_b, dbg_a, e[7:4], e[3:0]);
            end
            set_in(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            q.push_back({model_b(), model_a()});
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int edges;
        @(negedge clk);
        set_in(8'h01, 8'h01, 8'h01, 8'h01);
        repeat (LAT + 1) @(negedge clk);
        n_checks++;
        if (dbg_a !== 4'b1111) begin
            n_fail++;
            $display("FAIL pre_reset: got %b expected %b", dbg_a, 4'b1111);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dbg_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_a: got %b expected %b", dbg_a, 4'b0000);
        end
        n_checks++;
        if (dbg_b !== B_INV) begin
            n_fail++;
            $display("FAIL mid_reset_b: got %b expected %b", dbg_b, B_INV);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        edges = 0;
        while (dbg_a !== 4'b1111 && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_checks++;
        if (dbg_a !== 4'b1111 || edges != LAT) begin
            n_fail++;
            $display("FAIL post_reset: got %b after %0d edges, expected %b after %0d",
                     dbg_a, edges, 4'b1111, LAT);
        end
        n_checks++;
        if (dbg_b !== model_b()) begin
            n_fail++;
            $display("FAIL post_reset_b: got %b expected %b", dbg_b, model_b());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_in(8'h00, 8'h00, 8'h00, 8'h00);
        test_reset();
        test_directed();
        test_unselected();
        test_ch2_latency();
        test_random_stream();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_io_select.md
DEBUG_IO_SELECT -- requirements
Module: debug_io_select

Interface
REQ-001 Parameter CH0_SEL, default 0: bit index (0..7) of FSYNC_I routed to DEBUG_O[0].
REQ-002 Parameter CH1_SEL, default 0: bit index (0..7) of FSYNC_FILTER_I routed to DEBUG_O[1].
REQ-003 Parameter CH2_SEL, default 0: bit index (0..7) of VS_I routed to DEBUG_O[2].
REQ-004 Parameter CH3_SEL, default 0: bit index (0..7) of AUX_I routed to DEBUG_O[3].
REQ-005 Parameter INV_MASK, default 4'b0000: per-output inversion; a set bit inverts that DEBUG_O lane.
REQ-006 The design SHALL use one clock and an asynchronous, active-high reset.
REQ-007 The clock port SHALL be S_AXI_ACLK, input, 1 bit, the bus clock; all flops rise on it.
REQ-008 The reset port SHALL be S_AXI_ARESET, input, 1 bit, asynchronous, active-high.
REQ-009 FSYNC_I SHALL be an input, 8 bits: raw frame-sync debug group, asynchronous to S_AXI_ACLK.
REQ-010 FSYNC_FILTER_I SHALL be an input, 8 bits: filtered frame-sync debug group, asynchronous.
REQ-011 VS_I SHALL be an input, 8 bits: vertical-sync debug group, asynchronous.
REQ-012 AUX_I SHALL be an input, 8 bits: auxiliary debug group, asynchronous.
REQ-013 DEBUG_O SHALL be an output, 4 bits: registered debug pins, one lane per input group.

Function
REQ-014 Lane mapping: DEBUG_O[0]<-FSYNC_I[CH0_SEL], [1]<-FSYNC_FILTER_I[CH1_SEL], [2]<-VS_I[CH2_SEL], [3]<-AUX_I[CH3_SEL], each XOR INV_MASK[lane].
REQ-015 Only the selected bit of each group SHALL be sampled; toggling unselected bits SHALL never affect DEBUG_O.
REQ-016 DEBUG_O SHALL be driven directly from flops, with no combinational path from any input to DEBUG_O.
REQ-017 Latency, input change to DEBUG_O: 3 S_AXI_ACLK rising edges with DEBUG_IO_SYNC_EN, 1 edge without it.
REQ-018 Lanes SHALL be independent: simultaneous changes on several groups appear on DEBUG_O on the same edge.
REQ-019 An input pulse shorter than one clock period SHALL NOT be guaranteed to appear on DEBUG_O; a level held for at least 2 periods SHALL appear.
REQ-020 Select parameters SHALL be 3 bits wide so every value is in range; no out-of-range handling is needed.

Reset
REQ-021 While S_AXI_ARESET=1, all synchronizer and output flops SHALL clear to 0 asynchronously, so DEBUG_O=INV_MASK.
REQ-022 Reset asserted mid-operation SHALL force DEBUG_O=INV_MASK immediately, without waiting for a clock edge.
REQ-023 After reset deasserts, DEBUG_O SHALL follow the inputs with the normal latency from the first clock edge.

Configuration
REQ-024 Macro DEBUG_IO_SYNC_EN defined: each selected bit SHALL pass through a 2-flop synchronizer before the output flop (3-cycle latency).
REQ-025 Macro DEBUG_IO_SYNC_EN undefined: each selected bit SHALL be registered once into the output flop (1-cycle latency).

Structure
REQ-026 Package debug_io_select_pkg SHALL hold CH_COUNT=4, IN_W=8 and SEL_W=3.
REQ-027 The per-lane synchronizer SHALL be a sub-module, debug_io_sync (1-bit, 2 stages, async active-high reset), instantiated 4 times when DEBUG_IO_SYNC_EN is defined.

Verification
REQ-028 Hold reset for 500 ns, release, then set all groups to 8'h01 -> DEBUG_O=4'b1111 after the specified latency.
REQ-029 Set FSYNC_I=8'h00 and the other groups to 8'h01 -> DEBUG_O=4'b1110; set FSYNC_FILTER_I=8'h00 and the others to 8'h01 -> DEBUG_O=4'b1101.
REQ-030 Set only AUX_I=8'h01 and the other groups to 8'h00 -> DEBUG_O=4'b1000; set FSYNC_I=VS_I=8'h01 and the others to 8'h00 -> DEBUG_O=4'b0101.
REQ-031 Toggle bits 7..1 of all groups with bit 0 held at 0 -> DEBUG_O stays 4'b0000 throughout.
REQ-032 Assert reset while DEBUG_O=4'b1111 -> DEBUG_O=4'b0000 immediately; with INV_MASK=4'b1010, reset gives DEBUG_O=4'b1010.
REQ-033 Run with CH2_SEL=5 and VS_I=8'h20 -> DEBUG_O[2]=1; VS_I=8'h01 -> DEBUG_O[2]=0; count latency with and without DEBUG_IO_SYNC_EN (expect 3 and 1 edges).
